// File: rtl/frog_life_manager_if.sv
// Signal bundle between the collision/frog/car blocks and the frog life manager.
// The manager sits on the slave side: it consumes the i_* strobes and drives the o_* status.
interface frog_life_manager_if;
  logic       i_Frame_Tick;
  logic       i_Start;
  logic       i_Has_Collided;
  logic [8:0] i_Frog_Y;
  logic [1:0] o_State;
  logic [2:0] o_Lives;
  logic [2:0] o_Level;
  logic       o_Frog_Respawn;
  logic       o_Freeze;
  logic       o_Game_Over;

  modport master (
    output i_Frame_Tick, i_Start, i_Has_Collided, i_Frog_Y,
    input  o_State, o_Lives, o_Level, o_Frog_Respawn, o_Freeze, o_Game_Over
  );

  modport slave (
    input  i_Frame_Tick, i_Start, i_Has_Collided, i_Frog_Y,
    output o_State, o_Lives, o_Level, o_Frog_Respawn, o_Freeze, o_Game_Over
  );
endinterface

// File: rtl/frog_life_manager.sv
// Play / death / game-over sequencer: owns lives and level, drives respawn and freeze.
// Every output is a register; inputs only ever reach outputs through the single state process.
module frog_life_manager #(
  parameter int START_LIVES  = 3,
  parameter int MAX_LEVEL    = 7,
  parameter int DEATH_FRAMES = 60,
  parameter int GRACE_CYCLES = 2,
  parameter int TILE_SIZE    = 32
) (
  input  logic                i_Clk,
  input  logic                i_Rst_N,
  frog_life_manager_if.slave  bus
);

  localparam int DEATH_W = $clog2(DEATH_FRAMES + 1);
  localparam int GRACE_W = (GRACE_CYCLES < 1) ? 1 : $clog2(GRACE_CYCLES + 1);

  localparam logic [DEATH_W-1:0] DEATH_LAST = DEATH_W'(DEATH_FRAMES);
  localparam logic [DEATH_W-1:0] DEATH_ONE  = DEATH_W'(1);
  localparam logic [GRACE_W-1:0] GRACE_LOAD = GRACE_W'(GRACE_CYCLES);
  localparam logic [GRACE_W-1:0] GRACE_ONE  = GRACE_W'(1);
  localparam logic [2:0]         LIVES_LOAD = 3'(START_LIVES);
  localparam logic [2:0]         LEVEL_MAX  = 3'(MAX_LEVEL);
  localparam logic [8:0]         GOAL_Y     = 9'(TILE_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t               state_reg;
  logic [2:0]           lives_reg;
  logic [2:0]           level_reg;
  logic                 respawn_reg;
  logic                 freeze_reg;
  logic                 game_over_reg;
  logic [DEATH_W-1:0]   death_cnt_reg;
  logic [GRACE_W-1:0]   grace_reg;

  logic collide_hit;
  logic goal_hit;

  // Both events are masked while the post-respawn grace window is still open.
  assign collide_hit = bus.i_Has_Collided && (grace_reg == '0);
  assign goal_hit    = (bus.i_Frog_Y < GOAL_Y) && (grace_reg == '0);

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_N) begin
      state_reg     <= ST_IDLE;
      lives_reg     <= LIVES_LOAD;
      level_reg     <= 3'd0;
      respawn_reg   <= 1'b0;
      freeze_reg    <= 1'b1;
      game_over_reg <= 1'b0;
      death_cnt_reg <= '0;
      grace_reg     <= '0;
    end else begin
      respawn_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_OVER: begin
          if (bus.i_Start) begin
            state_reg     <= ST_PLAY;
            lives_reg     <= LIVES_LOAD;
            level_reg     <= 3'd0;
            respawn_reg   <= 1'b1;
            freeze_reg    <= 1'b0;
            game_over_reg <= 1'b0;
            grace_reg     <= GRACE_LOAD;
          end
        end

        ST_PLAY: begin
          if (grace_reg != '0) begin
            grace_reg <= grace_reg - GRACE_ONE;
          end
          // Collision has priority over a goal sampled on the same edge.
          if (collide_hit) begin
            freeze_reg <= 1'b1;
            if (lives_reg <= 3'd1) begin
              lives_reg     <= 3'd0;
              state_reg     <= ST_OVER;
              game_over_reg <= 1'b1;
            end else begin
              lives_reg     <= lives_reg - 3'd1;
              state_reg     <= ST_DYING;
              death_cnt_reg <= '0;
            end
          end else if (goal_hit) begin
            if (level_reg < LEVEL_MAX) begin
              level_reg <= level_reg + 3'd1;
            end
            respawn_reg <= 1'b1;
            grace_reg   <= GRACE_LOAD;
          end
        end

        ST_DYING: begin
          if (bus.i_Frame_Tick) begin
            death_cnt_reg <= death_cnt_reg + DEATH_ONE;
            if (death_cnt_reg + DEATH_ONE == DEATH_LAST) begin
              state_reg   <= ST_PLAY;
              respawn_reg <= 1'b1;
              freeze_reg  <= 1'b0;
              grace_reg   <= GRACE_LOAD;
            end
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_State        = state_reg;
  assign bus.o_Lives        = lives_reg;
  assign bus.o_Level        = level_reg;
  assign bus.o_Frog_Respawn = respawn_reg;
  assign bus.o_Freeze       = freeze_reg;
  assign bus.o_Game_Over    = game_over_reg;

endmodule

// File: tb/tb_frog_life_manager.sv
// Scoreboard bench: stimulus queues each expected output change with its cycle number;
// a negedge monitor pops an entry whenever the output tuple changes and compares.
module tb_frog_life_manager;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  bit   mon_en;

  frog_life_manager_if bus ();

  frog_life_manager dut (
    .i_Clk   (clk),
    .i_Rst_N (rst_n),
    .bus     (bus)
  );

  typedef struct {
    string      nm;
    int         cyc;
    logic [10:0] tup;
  } exp_t;

  exp_t sb[$];

  logic [2:0] m_lives;
  logic [2:0] m_level;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [10:0] pk(input logic [1:0] s, input logic [2:0] l,
                                     input logic [2:0] v, input logic r,
                                     input logic f, input logic g);
    return {s, l, v, r, f, g};
  endfunction

  task automatic push(input string nm, input int c, input logic [1:0] s,
                      input logic [2:0] l, input logic [2:0] v,
                      input logic r, input logic f, input logic g);
    exp_t e;
    e.nm  = nm;
    e.cyc = c;
    e.tup = pk(s, l, v, r, f, g);
    sb.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Monitor: every change of the observed tuple is one transaction.
  initial begin
    logic [10:0] cur;
    logic [10:0] prev;
    exp_t        e;
    prev = 'x;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = {bus.o_State, bus.o_Lives, bus.o_Level,
               bus.o_Frog_Respawn, bus.o_Freeze, bus.o_Game_Over};
        if (cur !== prev) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: cyc %0d got st=%0d lives=%0d lvl=%0d resp=%0b frz=%0b go=%0b, required no change",
                     cyc, cur[10:9], cur[8:6], cur[5:3], cur[2], cur[1], cur[0]);
          end else begin
            e = sb.pop_front();
            if (cur !== e.tup || cyc != e.cyc) begin
              errors++;
              $display("FAIL %s: got cyc %0d st=%0d lives=%0d lvl=%0d resp=%0b frz=%0b go=%0b, required cyc %0d st=%0d lives=%0d lvl=%0d resp=%0b frz=%0b go=%0b",
                       e.nm, cyc, cur[10:9], cur[8:6], cur[5:3], cur[2], cur[1], cur[0],
                       e.cyc, e.tup[10:9], e.tup[8:6], e.tup[5:3], e.tup[2], e.tup[1], e.tup[0]);
            end else begin
              $display("ok %s: cyc %0d st=%0d lives=%0d lvl=%0d resp=%0b frz=%0b go=%0b",
                       e.nm, cyc, cur[10:9], cur[8:6], cur[5:3], cur[2], cur[1], cur[0]);
            end
          end
          prev = cur;
        end
      end
    end
  end

  task automatic start_game(input string nm, input bit hold);
    int c;
    c = cyc;
    m_lives = 3'd3;
    m_level = 3'd0;
    push(nm, c + 1, 2'd1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0);
    push({nm, "_pulse_end"}, c + 2, 2'd1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0);
    bus.i_Start = 1'b1;
    step();
    if (hold) step();
    bus.i_Start = 1'b0;
  endtask

  task automatic collide(input string nm);
    int c;
    c = cyc;
    if (m_lives == 3'd1) begin
      m_lives = 3'd0;
      push(nm, c + 1, 2'd3, 3'd0, m_level, 1'b0, 1'b1, 1'b1);
    end else begin
      m_lives = m_lives - 3'd1;
      push(nm, c + 1, 2'd2, m_lives, m_level, 1'b0, 1'b1, 1'b0);
    end
    bus.i_Has_Collided = 1'b1;
    step();
    bus.i_Has_Collided = 1'b0;
  endtask

  // Start strobe while dying is ignored; the 60th frame tick respawns.
  task automatic die_sequence(input string nm);
    int c;
    bus.i_Start = 1'b1;
    step();
    bus.i_Start = 1'b0;
    step();
    for (int i = 0; i < 60; i++) begin
      if (i == 59) begin
        c = cyc;
        push(nm, c + 1, 2'd1, m_lives, m_level, 1'b1, 1'b0, 1'b0);
        push({nm, "_pulse_end"}, c + 2, 2'd1, m_lives, m_level, 1'b0, 1'b0, 1'b0);
      end
      bus.i_Frame_Tick = 1'b1;
      step();
      bus.i_Frame_Tick = 1'b0;
      if (i != 59) step();
    end
  endtask

  task automatic goal(input string nm, input logic [8:0] y);
    int c;
    c = cyc;
    if (m_level < 3'd7) m_level = m_level + 3'd1;
    push(nm, c + 1, 2'd1, m_lives, m_level, 1'b1, 1'b0, 1'b0);
    push({nm, "_pulse_end"}, c + 2, 2'd1, m_lives, m_level, 1'b0, 1'b0, 1'b0);
    bus.i_Frog_Y = y;
    step();
    bus.i_Frog_Y = 9'd200;
  endtask

  initial begin
    int c;
    cyc    = 0;
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    bus.i_Frame_Tick   = 1'b0;
    bus.i_Start        = 1'b0;
    bus.i_Has_Collided = 1'b0;
    bus.i_Frog_Y       = 9'd200;
    m_lives = 3'd3;
    m_level = 3'd0;

    repeat (3) @(posedge clk);
    #1;
    push("reset", cyc, 2'd0, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0);
    mon_en = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    step();

    start_game("start", 1'b0);

    // Collision held from the pulse cycle: first two samples fall in grace.
    c = cyc;
    m_lives = 3'd2;
    push("grace_collide", c + 3, 2'd2, 3'd2, 3'd0, 1'b0, 1'b1, 1'b0);
    bus.i_Has_Collided = 1'b1;
    repeat (50) step();
    bus.i_Has_Collided = 1'b0;
    die_sequence("respawn1");

    step(); step();
    collide("collide2");
    die_sequence("respawn2");
    step(); step();
    collide("collide3_over");

    bus.i_Frame_Tick = 1'b1;
    step();
    bus.i_Frame_Tick = 1'b0;
    repeat (3) step();
    start_game("restart", 1'b0);

    // Y equal to the tile size is not the goal row.
    step(); step();
    bus.i_Frog_Y = 9'd32;
    repeat (3) step();
    bus.i_Frog_Y = 9'd200;

    for (int i = 0; i < 9; i++) begin
      step(); step();
      goal($sformatf("goal%0d", i), (i == 8) ? 9'd31 : 9'd20);
    end

    step(); step();
    c = cyc;
    m_lives = 3'd2;
    push("collide_and_goal", c + 1, 2'd2, 3'd2, 3'd7, 1'b0, 1'b1, 1'b0);
    bus.i_Has_Collided = 1'b1;
    bus.i_Frog_Y       = 9'd20;
    step();
    bus.i_Has_Collided = 1'b0;
    bus.i_Frog_Y       = 9'd200;

    for (int i = 0; i < 5; i++) begin
      bus.i_Frame_Tick = 1'b1;
      step();
      bus.i_Frame_Tick = 1'b0;
      step();
    end
    c = cyc;
    push("reset_in_dying", c + 1, 2'd0, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (10) step();

    start_game("start_held", 1'b1);
    repeat (10) step();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations: got %0d outstanding, required 0 (next %s at cyc %0d)",
               sb.size(), sb[0].nm, sb[0].cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout at cyc %0d, required completion", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
